mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter sharing one data-memory port between instruction fetch and the memory stage. Both requesters drive address/control into this block. It grants one requester at a time and sequences fetch bursts of 1/4/8/16 words as per-word beats with incrementing addresses. It drives the memory's enable/address/size/direction pins and routes returned read data back with per-requester valid strobes.

## Interface
- STARVE_LIMIT, 4, consecutive memory-stage grants allowed while fetch is pending before fetch wins one arbitration (1..15)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- if_req  input  1  fetch request, held until if_gnt
- if_addr  input  32  fetch base address, word aligned
- if_access_size  input  2  burst length: 0=1, 1=4, 2=8, 3=16 words
- if_gnt  output  1  one-cycle pulse: fetch request captured
- if_rvalid  output  1  rd_data holds a fetch word this cycle
- if_last  output  1  with if_rvalid: final word of the burst
- dm_req  input  1  memory-stage request, held until dm_gnt
- dm_addr  input  32  load/store address
- dm_wdata  input  32  store data
- dm_rnw  input  1  1=load, 0=store
- dm_store_size  input  2  0=word, 1=halfword, 2=byte
- dm_gnt  output  1  one-cycle pulse: memory-stage request captured
- dm_rvalid  output  1  rd_data holds load data this cycle
- rd_data  output  32  pass-through of mem_data_out
- mem_address  output  32  beat address
- mem_data_in  output  32  store data
- mem_access_size  output  2  always 0 (per-word beats)
- mem_store_size  output  2  latched dm_store_size, 0 for fetch
- mem_read_not_write  output  1  beat direction
- mem_enable  output  1  beat request
- mem_busy  input  1  memory not accepting this cycle
- mem_data_out  input  32  registered memory read data

## Operation
- States: IDLE, IF_BURST, DM_ACCESS.
- IDLE arbitration, evaluated each cycle:
  - Only one request pending: that requester wins.
  - Both pending: dm wins unless starve_cnt == STARVE_LIMIT, in which case if wins.
- Winner's inputs are latched. The matching gnt pulses on the cycle the state register leaves IDLE.
- Beat accepted on a cycle with mem_enable=1 and mem_busy=0.
- IF_BURST:
  - mem_address = base + 4*beat_cnt; mem_read_not_write=1.
  - beat_cnt (4 bits) increments on each accept.
  - After accept of beat N-1: return to IDLE, clear beat_cnt.
- DM_ACCESS: single beat with latched addr/wdata/rnw/store_size. Return to IDLE on accept.
- mem_enable=1 in IF_BURST and DM_ACCESS, 0 in IDLE.
- starve_cnt (4 bits, saturating):
  - Increments when dm wins while if_req=1.
  - Clears when if wins or when if_req=0 in IDLE.
- Read return:
  - rvalid flops: if_rvalid/dm_rvalid assert the cycle after a read accept for that requester.
  - if_last asserts with the rvalid of beat N-1.
  - Stores produce no rvalid.
- Reset (asynchronous, any state, mid-burst included):
  - State=IDLE; beat_cnt and starve_cnt = 0.
  - All outputs 0.
  - Pending rvalid is dropped; the interrupted burst is not resumed.
- mem_busy held high: the beat holds with address, data and control stable. No timeout.

## Timing
- Grant latency: request visible at edge k → state leaves IDLE and gnt=1 at edge k+1. mem_enable=1 from k+1.
- Single read, no busy: accept in cycle k+1, rvalid in cycle k+2, IDLE in cycle k+2.
- N-word burst, no busy: N accepts in consecutive cycles k+1..k+N; rvalid in k+2..k+N+1.
- Next arbitration at the IDLE cycle after the last accept. Minimum one idle cycle on mem_enable between grants.
- Each mem_busy cycle stretches the current beat by one cycle. Later rvalids shift accordingly.
- A request raised during a burst waits; it is arbitrated only in IDLE.
- gnt, rvalid, last and all mem_* outputs are registered. rd_data is combinational pass-through.

## Configuration
- MEM_PORT_ARB_BURST_EN defined: if_access_size honoured (1/4/8/16 beats), beat_cnt present.
- Not defined:
  - Every fetch is a single word; if_access_size is ignored.
  - if_last asserts with every if_rvalid.
  - beat_cnt is removed.

## Test plan
- Fetch only, if_addr=0x100, size=1, no busy → if_gnt at edge 1. mem_address 0x100,0x104,0x108,0x10C on edges 1–4. if_rvalid on edges 2–5, if_last on edge 5.
- Both request every cycle, STARVE_LIMIT=2 → grant order dm,dm,if,dm,dm,if… starve_cnt resets to 0 after each if grant.
- Store dm_addr=0x40, dm_wdata=0xDEADBEEF, store_size=2 → one mem_enable beat with mem_read_not_write=0, mem_store_size=2, no dm_rvalid.
- mem_busy high 3 cycles on beat 1 of an 8-word burst → mem_address stays base+4 for 4 cycles. Total 8 rvalids; if_last on the 8th.
- rst low at beat 5 of a 16-word burst → all outputs 0 immediately, IDLE after release. A new dm_req is granted one edge after release.
- Macro undefined, if_access_size=3 → single beat, if_rvalid and if_last together.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch (bursts) and the memory stage.
// Define MEM_PORT_ARB_BURST_EN to honour if_access_size; otherwise every fetch is one word.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [1:0]  if_access_size,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic        if_last,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        dm_rnw,
    input  logic [1:0]  dm_store_size,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] rd_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic [1:0]  mem_store_size,
    output logic        mem_read_not_write,
    output logic        mem_enable,
    input  logic        mem_busy,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, IF_BURST, DM_ACCESS} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_starve, w_starve_nxt;
    logic       w_accept, w_if_win, w_dm_win, w_last_beat;

    assign rd_data         = mem_data_out;
    assign mem_access_size = 2'd0;
    assign w_accept        = mem_enable & ~mem_busy;

    // Fetch only beats the memory stage once it has been passed over STARVE_LIMIT times.
    assign w_if_win = (r_state == IDLE) && if_req && (!dm_req || r_starve == 4'(STARVE_LIMIT));
    assign w_dm_win = (r_state == IDLE) && dm_req && !w_if_win;

`ifdef MEM_PORT_ARB_BURST_EN
    logic [3:0] r_beat, r_len, w_len;
    assign w_last_beat = (r_beat == r_len);
    always_comb begin
        w_len = 4'd0;
        case (if_access_size)
            2'd1:    w_len = 4'd3;
            2'd2:    w_len = 4'd7;
            2'd3:    w_len = 4'd15;
            default: w_len = 4'd0;
        endcase
    end
`else
    logic [1:0] w_unused_size;
    assign w_unused_size = if_access_size;
    assign w_last_beat   = 1'b1;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        case (r_state)
            IDLE: begin
                if (w_if_win)      w_state_nxt = IF_BURST;
                else if (w_dm_win) w_state_nxt = DM_ACCESS;
                if (w_if_win || !if_req)           w_starve_nxt = 4'd0;
                else if (w_dm_win && r_starve != 4'hF) w_starve_nxt = r_starve + 4'd1;
            end
            IF_BURST:  if (w_accept && w_last_beat) w_state_nxt = IDLE;
            DM_ACCESS: if (w_accept)                w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state            <= IDLE;
            r_starve           <= 4'd0;
            if_gnt             <= 1'b0;
            dm_gnt             <= 1'b0;
            if_rvalid          <= 1'b0;
            if_last            <= 1'b0;
            dm_rvalid          <= 1'b0;
            mem_enable         <= 1'b0;
            mem_address        <= 32'd0;
            mem_data_in        <= 32'd0;
            mem_store_size     <= 2'd0;
            mem_read_not_write <= 1'b0;
`ifdef MEM_PORT_ARB_BURST_EN
            r_beat             <= 4'd0;
            r_len              <= 4'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_starve  <= w_starve_nxt;
            if_gnt    <= w_if_win;
            dm_gnt    <= w_dm_win;
            if_rvalid <= (r_state == IF_BURST) && w_accept;
            if_last   <= (r_state == IF_BURST) && w_accept && w_last_beat;
            dm_rvalid <= (r_state == DM_ACCESS) && w_accept && mem_read_not_write;
            case (r_state)
                IDLE: begin
                    if (w_if_win) begin
                        mem_enable         <= 1'b1;
                        mem_address        <= if_addr;
                        mem_data_in        <= 32'd0;
                        mem_store_size     <= 2'd0;
                        mem_read_not_write <= 1'b1;
`ifdef MEM_PORT_ARB_BURST_EN
                        r_beat             <= 4'd0;
                        r_len              <= w_len;
`endif
                    end else if (w_dm_win) begin
                        mem_enable         <= 1'b1;
                        mem_address        <= dm_addr;
                        mem_data_in        <= dm_wdata;
                        mem_store_size     <= dm_store_size;
                        mem_read_not_write <= dm_rnw;
                    end
                end
                IF_BURST: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            mem_enable         <= 1'b0;
                            mem_address        <= 32'd0;
                            mem_read_not_write <= 1'b0;
`ifdef MEM_PORT_ARB_BURST_EN
                            r_beat             <= 4'd0;
`endif
                        end else begin
                            // Address register tracks base + 4*beat_cnt.
                            mem_address <= mem_address + 32'd4;
`ifdef MEM_PORT_ARB_BURST_EN
                            r_beat      <= r_beat + 4'd1;
`endif
                        end
                    end
                end
                DM_ACCESS: begin
                    if (w_accept) begin
                        mem_enable         <= 1'b0;
                        mem_address        <= 32'd0;
                        mem_data_in        <= 32'd0;
                        mem_store_size     <= 2'd0;
                        mem_read_not_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
